// File: rtl/traffic_light_ctrl_if.sv
// traffic_light_ctrl_if
//   Sensor/lamp bundle between the intersection controller and its
//   surroundings. The master side (sensors, lamp observers) drives the car
//   sensors and reads the lamps; the slave side is the controller.
//   NSCar, EWCar     : car sensors, level or pulse
//   NSLite, EWLite   : lamps {red, yellow, green}, one-hot
//   phase            : current controller state code
interface traffic_light_ctrl_if;
  logic       NSCar;
  logic       EWCar;
  logic [2:0] NSLite;
  logic [2:0] EWLite;
  logic [2:0] phase;

  modport master (
    output NSCar, EWCar,
    input  NSLite, EWLite, phase
  );

  modport slave (
    input  NSCar, EWCar,
    output NSLite, EWLite, phase
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   Two-direction intersection controller: green / yellow / all-red
//   sequencing with a programmable minimum green, yellow and all-red
//   clearance, and latched car requests so a one-cycle sensor pulse is
//   never lost.
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : sensors in (NSCar, EWCar), lamps and phase out (Moore)
module traffic_light_ctrl #(
  parameter int GREEN_MIN   = 8,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int CNT_W       = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  traffic_light_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_TO_EW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_TO_NS = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TIME - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_next;
  logic             r_ew_req;
  logic             r_ns_req;
  logic             w_ew_req_next;
  logic             w_ns_req_next;
  logic             w_enter_ew;
  logic             w_enter_ns;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= NS_GREEN;
      r_timer  <= '0;
      r_ew_req <= 1'b0;
      r_ns_req <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_timer  <= w_timer_next;
      r_ew_req <= w_ew_req_next;
      r_ns_req <= w_ns_req_next;
    end
  end

  // Next state. The live sensor is OR-ed with the latch so a request seen
  // on the very edge where green may end takes effect on that edge.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      NS_GREEN:  if (r_timer >= GREEN_LAST && (r_ew_req || bus.EWCar)) w_next = NS_YELLOW;
      NS_YELLOW: if (r_timer == YELLOW_LAST) w_next = RED_TO_EW;
      RED_TO_EW: if (r_timer == ALLRED_LAST) w_next = EW_GREEN;
      EW_GREEN:  if (r_timer >= GREEN_LAST && (r_ns_req || bus.NSCar)) w_next = EW_YELLOW;
      EW_YELLOW: if (r_timer == YELLOW_LAST) w_next = RED_TO_NS;
      RED_TO_NS: if (r_timer == ALLRED_LAST) w_next = NS_GREEN;
      default:   w_next = NS_GREEN;
    endcase
  end

  // Phase timer: restarts on any state change, otherwise saturates.
  always_comb begin
    w_timer_next = r_timer;
    if (w_next != r_state) begin
      w_timer_next = '0;
    end else if (r_timer != '1) begin
      w_timer_next = r_timer + 1'b1;
    end
  end

  // Request latches: clearing on entry to the served green beats a set
  // on the same edge; a sensor seen during its own green is ignored.
  always_comb begin
    w_enter_ew    = (w_next == EW_GREEN) && (r_state != EW_GREEN);
    w_enter_ns    = (w_next == NS_GREEN) && (r_state != NS_GREEN);
    w_ew_req_next = r_ew_req;
    w_ns_req_next = r_ns_req;
    if (w_enter_ew) begin
      w_ew_req_next = 1'b0;
    end else if (bus.EWCar && r_state != EW_GREEN) begin
      w_ew_req_next = 1'b1;
    end
    if (w_enter_ns) begin
      w_ns_req_next = 1'b0;
    end else if (bus.NSCar && r_state != NS_GREEN) begin
      w_ns_req_next = 1'b1;
    end
  end

  // Moore lamp decode; unreachable codes show all-red until recovery.
  always_comb begin
    bus.NSLite = LAMP_RED;
    bus.EWLite = LAMP_RED;
    bus.phase  = r_state;
    unique case (r_state)
      NS_GREEN:  bus.NSLite = LAMP_GREEN;
      NS_YELLOW: bus.NSLite = LAMP_YELLOW;
      EW_GREEN:  bus.EWLite = LAMP_GREEN;
      EW_YELLOW: bus.EWLite = LAMP_YELLOW;
      default:   ;
    endcase
  end

endmodule
